spi_link: RTL and testbench

- Full-duplex 128-bit SPI link: one master controller (spi_link top-level logic) and one slave endpoint (sub-module spi_sub_core).
- Both run in a single system-clock domain.
- The master sends a 128-bit block to the slave and simultaneously receives the slave's 128-bit block. This is the transport between a host and the AES core.
- Bus pins are exported for observation.

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_sub_core.sv | 73 +++++++
 rtl/spi_link.sv | 118 +++++++++++
 tb/tb_spi_link.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants for the SPI link: default geometry and master FSM state encoding.
package spi_pkg;

    localparam int SPI_DATA_W  = 128;
    localparam int SPI_CLK_DIV = 2;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_SETUP = 3'd1;
    localparam state_t ST_HIGH  = 3'd2;
    localparam state_t ST_LOW   = 3'd3;
    localparam state_t ST_HOLD  = 3'd4;

endpackage

// File: rtl/spi_sub_core.sv
// SPI mode-0 slave endpoint: oversamples cs_n/sclk on clk and shifts MSB first.
module spi_sub_core
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_n,
    input  logic              sclk,
    input  logic              mosi,
    input  logic [DATA_W-1:0] tx_sub,
    output logic              miso,
    output logic [DATA_W-1:0] rx_sub,
    output logic              done_sub
);

    localparam int CW = $clog2(DATA_W + 1);

    logic              cs_q;
    logic              sclk_q;
    logic              miso_r;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] tx_sh;
    logic [DATA_W-1:0] rx_sh;

    logic cs_fall, cs_rise, sclk_rise, sclk_fall;

    assign cs_fall   = cs_q & ~cs_n;
    assign cs_rise   = ~cs_q & cs_n;
    assign sclk_rise = ~sclk_q & sclk & ~cs_n;
    assign sclk_fall = sclk_q & ~sclk & ~cs_n;

    // The bus is only driven while selected, independent of the internal bit register.
    assign miso = miso_r & ~cs_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_q     <= 1'b1;
            sclk_q   <= 1'b0;
            miso_r   <= 1'b0;
            cnt      <= '0;
            rx_sub   <= '0;
            done_sub <= 1'b0;
        end else begin
            cs_q     <= cs_n;
            sclk_q   <= sclk;
            done_sub <= 1'b0;
            if (cs_fall) begin
                tx_sh  <= tx_sub;
                miso_r <= tx_sub[DATA_W-1];
                cnt    <= '0;
            end else if (cs_rise) begin
                miso_r <= 1'b0;
                // A truncated frame is dropped so the AES side never sees a partial word.
                if (cnt == CW'(DATA_W)) begin
                    rx_sub   <= rx_sh;
                    done_sub <= 1'b1;
                end
            end else begin
                if (sclk_rise) begin
                    rx_sh <= {rx_sh[DATA_W-2:0], mosi};
                    cnt   <= cnt + 1'b1;
                end
                if (sclk_fall) begin
                    tx_sh  <= tx_sh << 1;
                    miso_r <= tx_sh[DATA_W-2];
                end
            end
        end
    end

endmodule

// File: rtl/spi_link.sv
// Full-duplex SPI link: inline mode-0 master FSM plus the slave endpoint it talks to.
module spi_link
    import spi_pkg::*;
#(
    parameter int DATA_W  = SPI_DATA_W,
    parameter int CLK_DIV = SPI_CLK_DIV
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_main,
    output logic [DATA_W-1:0] rx_main,
    output logic              done,
    input  logic [DATA_W-1:0] tx_sub,
    output logic [DATA_W-1:0] rx_sub,
    output logic              done_sub,
    output logic              cs_n,
    output logic              sclk,
    output logic              mosi,
    output logic              miso
);

    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam int CNT_W = $clog2(DATA_W);

    state_t            state;
    logic              start_q;
    logic [DIV_W-1:0]  div_cnt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] tx_sh;
    logic [DATA_W-1:0] rx_sh;
    logic              phase_end;

    assign phase_end = (div_cnt == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            start_q <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            cs_n    <= 1'b1;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            rx_main <= '0;
            done    <= 1'b0;
        end else begin
            // start_q tracks start in every state so a level held across completion cannot retrigger.
            start_q <= start;
            done    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !start_q) begin
                        tx_sh   <= tx_main;
                        cs_n    <= 1'b0;
                        mosi    <= tx_main[DATA_W-1];
                        bit_cnt <= '0;
                        div_cnt <= '0;
                        state   <= ST_SETUP;
                    end
                end
                ST_SETUP, ST_LOW: begin
                    if (phase_end) begin
                        div_cnt <= '0;
                        sclk    <= 1'b1;
                        rx_sh   <= {rx_sh[DATA_W-2:0], miso};
                        state   <= ST_HIGH;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (phase_end) begin
                        div_cnt <= '0;
                        sclk    <= 1'b0;
                        if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                            state <= ST_HOLD;
                        end else begin
                            tx_sh   <= tx_sh << 1;
                            mosi    <= tx_sh[DATA_W-2];
                            bit_cnt <= bit_cnt + 1'b1;
                            state   <= ST_LOW;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (phase_end) begin
                        div_cnt <= '0;
                        cs_n    <= 1'b1;
                        rx_main <= rx_sh;
                        done    <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    spi_sub_core #(
        .DATA_W (DATA_W)
    ) u_sub (
        .clk      (clk),
        .rst      (rst),
        .cs_n     (cs_n),
        .sclk     (sclk),
        .mosi     (mosi),
        .tx_sub   (tx_sub),
        .miso     (miso),
        .rx_sub   (rx_sub),
        .done_sub (done_sub)
    );

endmodule

// File: tb/tb_spi_link.sv
// Bench for spi_link: word/bit-level reference model checked every cycle plus directed literal checks.
module tb_spi_link;
    import spi_pkg::*;

    localparam int DW = SPI_DATA_W;
    localparam int CD = SPI_CLK_DIV;
    localparam int LAT_LO  = 2 * DW * CD;
    localparam int LAT_HI  = CD * (2 * DW + 2) + 3;
    localparam int LAT_MAX = CD * (2 * DW + 2) + 40;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [DW-1:0] tx_main, tx_sub, rx_main, rx_sub;
    logic          done, done_sub, cs_n, sclk, mosi, miso;

    always #5 clk = ~clk;

    spi_link #(.DATA_W(DW), .CLK_DIV(CD)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .tx_main  (tx_main),
        .rx_main  (rx_main),
        .done     (done),
        .tx_sub   (tx_sub),
        .rx_sub   (rx_sub),
        .done_sub (done_sub),
        .cs_n     (cs_n),
        .sclk     (sclk),
        .mosi     (mosi),
        .miso     (miso)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: a transfer is one word each way, serialized MSB first.
    bit            busy = 1'b0;
    int            lat = 0, rise_cnt = 0, hi_len = 0;
    int            n_done = 0, n_done_sub = 0;
    logic          start_prev = 1'b0, sclk_prev = 1'b0;
    logic [DW-1:0] cur_main = '0, cur_sub = '0, hold_main = '0, hold_sub = '0;
    logic [DW-1:0] q_sub[$];

    always @(negedge clk) begin
        if (rst) begin
            busy = 1'b0;
            q_sub.delete();
            hold_main = '0;
            hold_sub = '0;
            start_prev = 1'b0;
            sclk_prev = 1'b0;
            rise_cnt = 0;
            hi_len = 0;
        end else begin
            if (busy) lat++;
            if (busy && sclk && !sclk_prev) begin
                if (rise_cnt < DW) begin
                    chk("mosi_bit", DW'(mosi), DW'(cur_main[DW-1-rise_cnt]));
                    chk("miso_bit", DW'(miso), DW'(cur_sub[DW-1-rise_cnt]));
                end
                rise_cnt++;
            end
            if (sclk) hi_len++;
            if (busy && !sclk && sclk_prev) chk("sclk_high_len", DW'(hi_len), DW'(CD));
            if (!sclk) hi_len = 0;
            if (!busy) begin
                chk("idle_cs_n", DW'(cs_n), DW'(1));
                chk("idle_sclk", DW'(sclk), DW'(0));
                chk("idle_miso", DW'(miso), DW'(0));
            end
            if (done) begin
                n_done++;
                chk("done_while_busy", DW'(busy), DW'(1));
                if (busy) begin
                    chk("sclk_rise_count", DW'(rise_cnt), DW'(DW));
                    chk("latency_window", DW'(lat >= LAT_LO && lat <= LAT_HI), DW'(1));
                    hold_main = cur_sub;
                end
                busy = 1'b0;
            end
            if (done_sub) begin
                n_done_sub++;
                chk("done_sub_expected", DW'(q_sub.size() > 0), DW'(1));
                if (q_sub.size() > 0) hold_sub = q_sub.pop_front();
            end
            chk("rx_main_model", rx_main, hold_main);
            chk("rx_sub_model", rx_sub, hold_sub);
            if (busy && lat > LAT_MAX) begin
                chk("xfer_timeout", DW'(0), DW'(1));
                busy = 1'b0;
            end
            if (!busy && start && !start_prev) begin
                busy = 1'b1;
                lat = 0;
                rise_cnt = 0;
                cur_main = tx_main;
                cur_sub = tx_sub;
                q_sub.push_back(tx_main);
            end
            start_prev = start;
            sclk_prev = sclk;
        end
    end

    task automatic wait_done(input int target);
        for (int i = 0; i < 700 && n_done < target; i++) @(posedge clk);
        chk("done_arrived", DW'(n_done >= target), DW'(1));
    endtask

    task automatic xfer(input logic [DW-1:0] m, input logic [DW-1:0] s,
                        input logic [DW-1:0] exp_main, input logic [DW-1:0] exp_sub);
        int target;
        target = n_done + 1;
        @(posedge clk); #1;
        tx_main = m;
        tx_sub = s;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(target);
        @(negedge clk);
        chk("lit_rx_main", rx_main, exp_main);
        @(negedge clk);
        chk("lit_rx_sub", rx_sub, exp_sub);
    endtask

    initial begin
        int base;
        rst = 1'b1;
        start = 1'b0;
        tx_main = '0;
        tx_sub = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_cs_n", DW'(cs_n), DW'(1));
        chk("rst_sclk", DW'(sclk), DW'(0));
        chk("rst_mosi", DW'(mosi), DW'(0));
        chk("rst_miso", DW'(miso), DW'(0));
        chk("rst_rx_main", rx_main, '0);
        chk("rst_rx_sub", rx_sub, '0);
        chk("rst_done", DW'(done), DW'(0));
        chk("rst_done_sub", DW'(done_sub), DW'(0));

        // Abort a transfer around bit 40.
        @(posedge clk); #1;
        tx_main = 128'hdeadbeefcafef00d0123456789abcdef;
        tx_sub = 128'h13579bdf2468ace0fedcba9876543210;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 400 && rise_cnt < 40; i++) @(posedge clk);
        chk("reached_bit40", DW'(rise_cnt >= 40), DW'(1));
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("abort_cs_n", DW'(cs_n), DW'(1));
        chk("abort_sclk", DW'(sclk), DW'(0));
        chk("abort_rx_main", rx_main, '0);
        chk("abort_rx_sub", rx_sub, '0);
        chk("abort_no_done", DW'(n_done), DW'(0));
        chk("abort_no_done_sub", DW'(n_done_sub), DW'(0));

        // Basic transfer with start held for 10 cycles.
        @(posedge clk); #1;
        tx_main = 128'h00112233445566778899aabbccddeeff;
        tx_sub = '0;
        start = 1'b1;
        repeat (10) @(posedge clk);
        #1 start = 1'b0;
        wait_done(1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("basic_rx_sub", rx_sub, 128'h00112233445566778899aabbccddeeff);
        chk("basic_rx_main", rx_main, '0);
        chk("basic_done_once", DW'(n_done), DW'(1));
        chk("basic_done_sub_once", DW'(n_done_sub), DW'(1));

        // Back-to-back transfers.
        xfer(128'h99999999999999999, 128'h555555555555555555,
             128'h555555555555555555, 128'h99999999999999999);
        xfer(128'habde1, 128'hfa4d, 128'hfa4d, 128'habde1);

        // Retrigger mid-transfer, inputs changed mid-transfer, start held across completion.
        base = n_done;
        @(posedge clk); #1;
        tx_main = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;
        tx_sub = 128'h0123456789abcdeffedcba9876543210;
        start = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        tx_main = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
        tx_sub = 128'hfedcba98765432100123456789abcdef;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        wait_done(base + 1);
        repeat (600) @(posedge clk);
        @(negedge clk);
        chk("retrig_single_done", DW'(n_done - base), DW'(1));
        chk("latched_rx_sub", rx_sub, 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f);
        chk("latched_rx_main", rx_main, 128'h0123456789abcdeffedcba9876543210);

        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        wait_done(base + 2);
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("restart_rx_sub", rx_sub, 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0);
        chk("restart_rx_main", rx_main, 128'hfedcba98765432100123456789abcdef);
        chk("restart_done_count", DW'(n_done - base), DW'(2));
        repeat (10) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
